hd44780_read_operation: RTL and testbench
=========================================

Name: hd44780_read_operation

Overview:
- Read-side counterpart to the LCD write path. Performs HD44780 read cycles (RW=1): either busy-flag/address-counter polling (RS=0) or a single DDRAM/CGRAM data read (RS=1).
- Generates RS/RW/E timing, tells the top level when to tri-state the FPGA data-bus drivers, samples D[7:0] and returns the byte.
- Sits beside the write FSM. The control FSM uses it to wait for BF=0 instead of fixed delays.

Parameters:
- T_AS_CYC, 4, clocks RS/RW are held stable before E rises (40 ns @100 MHz)
- T_EH_CYC, 25, clocks E is held high (250 ns)
- T_EL_CYC, 25, clocks E is held low after each pulse (total E cycle ≥ 500 ns)
- MAX_POLLS, 255, maximum BF reads per poll request before timeout (≥1)

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous active-high reset
- i_ena  input  1  clock enable; when low, all state and counters freeze
- i_start  input  1  one-cycle request, accepted only in IDLE with i_ena=1
- i_rs  input  1  captured at start: 0 = busy poll, 1 = single data read
- i_d  input  8  LCD data bus as seen by the FPGA input buffers
- o_rs  output  1  LCD RS
- o_rw  output  1  LCD R/W (1 = read)
- o_e  output  1  LCD enable
- o_bus_release  output  1  1 = top level must tri-state its D drivers
- o_busy  output  1  high from the accept cycle until return to IDLE
- o_valid  output  1  one-cycle pulse; o_data/o_bf/o_ac are valid
- o_data  output  8  last sampled byte
- o_bf  output  1  o_data[7] when RS=0 (last read)
- o_ac  output  7  o_data[6:0] when RS=0 (last read)
- o_timeout  output  1  set with o_valid if the poll ended with BF still 1

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation):
  - o_e=0, o_rw=0, o_rs=0, o_bus_release=0, o_busy=0, o_valid=0, o_timeout=0
  - o_data=0, o_bf=0, o_ac=0
  - FSM in IDLE, all counters 0
- States:
  - IDLE → SETUP on i_start & i_ena. Capture i_rs. Clear poll count and o_timeout.
  - SETUP: o_rw=1, o_rs=captured, o_bus_release=1, o_e=0. Hold T_AS_CYC clocks, then go to E_HIGH.
  - E_HIGH: o_e=1 for T_EH_CYC clocks. On the clock edge that ends E_HIGH, register i_d into o_data; o_e falls on that same edge.
  - E_LOW: o_e=0, RS/RW held, bus still released. Hold T_EL_CYC clocks, then:
    - RS=1 → DONE.
    - RS=0 & i_d-sampled bit7=1 & poll count < MAX_POLLS-1 → increment count, go to E_HIGH. The setup time is already satisfied, so SETUP is not repeated.
    - otherwise → DONE. o_timeout=1 if bit7 is still 1.
  - DONE: o_valid=1 for one clock. o_rw=0, o_rs=0, o_bus_release=0 on the DONE→IDLE edge. Return to IDLE.
- Latency with defaults:
  - single read: o_valid is high 55 clocks after the accepting edge (4+25+25+1)
  - each extra poll adds T_EH_CYC+T_EL_CYC = 50 clocks
- o_bus_release stays 1 throughout SETUP..DONE, so the writer and this block never drive the bus simultaneously.
- o_busy=1 in every non-IDLE state.
- i_start while busy is ignored; it is not queued.
- o_data/o_bf/o_ac hold their values until the next sample.
- i_ena=0 mid-operation stretches the current phase. Outputs hold and no edges are lost.
- Counters are sized with $clog2 of the largest parameter. Counts are exact: a phase of N cycles is N clocks.

Optional Feature:
- HD44780_4BIT_EN:
  - Defined: each logical read uses two E pulses (E_HIGH/E_LOW twice). The high nibble is sampled from i_d[7:4] on pulse 1 and the low nibble from i_d[7:4] on pulse 2. o_data is assembled from the two nibbles. The BF decision is made only after the second pulse, and i_d[3:0] is ignored.
  - Single-read latency becomes 4+2×50+1 = 105 clocks; each extra poll adds 100 clocks.
  - Undefined: 8-bit operation as described above.

Test Plan:
- Data read: reset, i_rs=1, i_start, i_d=8'h5A → o_rs=1, o_rw=1, o_bus_release=1, one E pulse 25 clocks high; o_valid exactly 55 clocks after start; o_data=8'h5A; o_timeout=0.
- Busy poll: i_rs=0, i_d=8'h85 for the first 3 samples then 8'h05 → 4 E pulses; o_valid once; o_bf=0; o_ac=7'h05; o_timeout=0; total 205 clocks.
- Timeout: MAX_POLLS=3, i_d held at 8'hFF → exactly 3 E pulses; o_valid with o_timeout=1, o_bf=1.
- Reset mid-operation: assert i_reset during E_HIGH → o_e, o_rw, o_bus_release go 0 immediately with no clock; a new i_start after release gives a normal 55-clock read.
- Start while busy and enable gating: a second i_start during SETUP is ignored, with one o_valid only; i_ena low for 10 clocks in E_HIGH gives an E-high width of 35 clocks and o_valid at 65 clocks.
- With HD44780_4BIT_EN: i_d[7:4]=4'hA then 4'h3 → o_data=8'hA3, 2 E pulses, o_valid at 105 clocks.

Source files
------------

// File: rtl/hd44780_read_operation.sv
// HD44780 read-cycle engine (RW=1): busy-flag/address polling (RS=0) or a
// single DDRAM/CGRAM data read (RS=1). Drives RS/RW/E timing, requests bus
// release from the top level, samples D[7:0] and reports the byte.
// Optional build macro HD44780_4BIT_EN: two E pulses per logical read, high
// nibble then low nibble, both taken from i_d[7:4].
module hd44780_read_operation #(
    parameter int T_AS_CYC  = 4,
    parameter int T_EH_CYC  = 25,
    parameter int T_EL_CYC  = 25,
    parameter int MAX_POLLS = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_d,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_e,
    output logic       o_bus_release,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_bf,
    output logic [6:0] o_ac,
    output logic       o_timeout
);

    localparam int MAX_AB = (T_AS_CYC > T_EH_CYC) ? T_AS_CYC : T_EH_CYC;
    localparam int MAX_CD = (T_EL_CYC > MAX_POLLS) ? T_EL_CYC : MAX_POLLS;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HIGH,
        E_LOW,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   poll;
    logic            rs_cap;
    logic [7:0]      data;
    logic            timeout;
    logic            last_as;
    logic            last_eh;
    logic            last_el;
    logic            more_polls;
    logic            read_done;
    logic            rs_next;

    logic            rs_q;
    logic            rw_q;
    logic            e_q;
    logic            release_q;
    logic            busy_q;
    logic            valid_q;

`ifdef HD44780_4BIT_EN
    logic            second;
    logic [3:0]      hi_nib;
    logic            unused_low_nibble;

    assign unused_low_nibble = ^i_d[3:0];
    assign read_done         = second;
`else
    assign read_done         = 1'b1;
`endif

    assign last_as    = (cnt == CW'(T_AS_CYC - 1));
    assign last_eh    = (cnt == CW'(T_EH_CYC - 1));
    assign last_el    = (cnt == CW'(T_EL_CYC - 1));
    // Another BF read is needed only for polls whose last byte still shows busy
    assign more_polls = !rs_cap && data[7] && (poll < CW'(MAX_POLLS - 1));
    // RS is captured on the accepting edge, so the output register must see i_rs there
    assign rs_next    = (state == IDLE) ? i_rs : rs_cap;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a low enable freezes the current phase
    always_comb begin
        state_next = state;
        if (i_ena) begin
            unique case (state)
                IDLE:   if (i_start) state_next = SETUP;
                SETUP:  if (last_as) state_next = E_HIGH;
                E_HIGH: if (last_eh) state_next = E_LOW;
                E_LOW: begin
                    if (last_el) begin
                        if (!read_done || more_polls) begin
                            state_next = E_HIGH;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Phase counter, poll counter, RS capture, bus sampling and timeout flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= '0;
            poll    <= '0;
            rs_cap  <= 1'b0;
            data    <= '0;
            timeout <= 1'b0;
`ifdef HD44780_4BIT_EN
            second  <= 1'b0;
            hi_nib  <= '0;
`endif
        end else if (i_ena) begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_start) begin
                        rs_cap  <= i_rs;
                        poll    <= '0;
                        timeout <= 1'b0;
`ifdef HD44780_4BIT_EN
                        second  <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    cnt <= last_as ? '0 : cnt + 1'b1;
                end
                E_HIGH: begin
                    cnt <= last_eh ? '0 : cnt + 1'b1;
                    if (last_eh) begin
`ifdef HD44780_4BIT_EN
                        if (!second) begin
                            hi_nib <= i_d[7:4];
                        end else begin
                            data <= {hi_nib, i_d[7:4]};
                        end
`else
                        data <= i_d;
`endif
                    end
                end
                E_LOW: begin
                    cnt <= last_el ? '0 : cnt + 1'b1;
                    if (last_el) begin
`ifdef HD44780_4BIT_EN
                        second <= !second;
`endif
                        if (read_done) begin
                            if (more_polls) begin
                                poll <= poll + 1'b1;
                            end else begin
                                timeout <= !rs_cap && data[7];
                            end
                        end
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Registered LCD control pins and handshake, decoded from the next state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            e_q       <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else if (i_ena) begin
            rs_q      <= (state_next != IDLE) && rs_next;
            rw_q      <= (state_next != IDLE);
            e_q       <= (state_next == E_HIGH);
            release_q <= (state_next != IDLE);
            busy_q    <= (state_next != IDLE);
            valid_q   <= (state_next == DONE);
        end
    end

    assign o_rs          = rs_q;
    assign o_rw          = rw_q;
    assign o_e           = e_q;
    assign o_bus_release = release_q;
    assign o_busy        = busy_q;
    assign o_valid       = valid_q;
    assign o_data        = data;
    assign o_bf          = data[7];
    assign o_ac          = data[6:0];
    assign o_timeout     = timeout;

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Self-checking bench for hd44780_read_operation: a timeline model indexed by
// the enabled-cycle position inside an operation, random and directed reads.
module tb_hd44780_read_operation;

    localparam int TAS    = 4;
    localparam int TEH    = 25;
    localparam int TEL    = 25;
    localparam int PER    = TEH + TEL;
    localparam int TB_MAX = 4;
`ifdef HD44780_4BIT_EN
    localparam int R         = 2;
    localparam int LAT1      = 105;
    localparam int LAT4      = 405;
    localparam int GATE_E    = 60;
    localparam int GATE_LAT  = 115;
    localparam logic [7:0] DATA_LIT = 8'hA3;
`else
    localparam int R         = 1;
    localparam int LAT1      = 55;
    localparam int LAT4      = 205;
    localparam int GATE_E    = 35;
    localparam int GATE_LAT  = 65;
    localparam logic [7:0] DATA_LIT = 8'h5A;
`endif

    logic       i_clk   = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ena   = 1'b1;
    logic       i_start = 1'b0;
    logic       i_rs    = 1'b0;
    logic [7:0] i_d     = 8'h00;
    logic       o_rs, o_rw, o_e, o_bus_release, o_busy, o_valid, o_bf, o_timeout;
    logic [7:0] o_data;
    logic [6:0] o_ac;

    always #5 i_clk = ~i_clk;

    hd44780_read_operation #(
        .T_AS_CYC (TAS),
        .T_EH_CYC (TEH),
        .T_EL_CYC (TEL),
        .MAX_POLLS(TB_MAX)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_ena        (i_ena),
        .i_start      (i_start),
        .i_rs         (i_rs),
        .i_d          (i_d),
        .o_rs         (o_rs),
        .o_rw         (o_rw),
        .o_e          (o_e),
        .o_bus_release(o_bus_release),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_bf         (o_bf),
        .o_ac         (o_ac),
        .o_timeout    (o_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: k = enabled cycles since the accepting edge (0 = idle)
    int         k         = 0;
    int         exp_total = 0;
    int         lreads    = 0;
    logic       cur_rs    = 1'b0;
    logic [7:0] exp_byte  = 8'h00;
    logic       exp_to    = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_to   = 1'b0;
    logic [7:0] plan [TB_MAX];

    int   real_cyc  = 0;
    int   valid_at  = 0;
    int   valid_cnt = 0;
    int   e_cnt     = 0;
    int   e_pulses  = 0;
    logic prev_e    = 1'b0;

    int ena_mode     = 0;
    int ena_low_left = 0;
    int ena_gate_at  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of logical reads the operation needs, from the planned bytes
    function automatic int logical_reads(input logic rs);
        if (rs) return 1;
        for (int i = 0; i < TB_MAX; i++) begin
            if (!plan[i][7]) return i + 1;
        end
        return TB_MAX;
    endfunction

    function automatic logic [7:0] pulse_val(input int j);
        logic [7:0] b;
        logic [3:0] junk;
        junk = 4'($urandom_range(0, 15));
        if (R == 1) return plan[j];
        b = plan[j / 2];
        if ((j % 2) == 0) return {b[7:4], junk};
        return {b[3:0], junk};
    endfunction

    function automatic logic in_e_high(input int kk);
        return (kk > TAS) && (kk < exp_total) && (((kk - TAS - 1) % PER) < TEH);
    endfunction

    // Reference model advance and per-cycle output comparison
    always begin
        @(posedge i_clk);
        if (i_reset) begin
            k         = 0;
            held_data = 8'h00;
            held_to   = 1'b0;
        end else if (i_ena) begin
            if (k == 0) begin
                if (i_start) begin
                    cur_rs    = i_rs;
                    lreads    = logical_reads(i_rs);
                    exp_total = TAS + lreads * R * PER + 1;
                    exp_byte  = plan[lreads - 1];
                    exp_to    = !i_rs && plan[lreads - 1][7];
                    k         = 1;
                    real_cyc  = 0;
                    valid_at  = 0;
                    valid_cnt = 0;
                    e_cnt     = 0;
                    e_pulses  = 0;
                end
            end else if (k == exp_total) begin
                k = 0;
            end else begin
                k++;
                if (k == exp_total) begin
                    held_data = exp_byte;
                    held_to   = exp_to;
                end
            end
        end
        if (k != 0) real_cyc++;
        #1;
        check("busy", o_busy, k != 0);
        check("rw", o_rw, k != 0);
        check("bus_release", o_bus_release, k != 0);
        check("rs", o_rs, (k != 0) && cur_rs);
        check("e", o_e, in_e_high(k));
        check("valid", o_valid, (k != 0) && (k == exp_total));
        check("timeout", o_timeout, (k == 0 || k == exp_total) ? held_to : 1'b0);
        if (k == 0 || k == exp_total) check("data", o_data, held_data);
        if (k != 0 && k == exp_total && !cur_rs) begin
            check("bf", o_bf, held_data[7]);
            check("ac", o_ac, held_data[6:0]);
        end
        if (o_e && !prev_e) e_pulses++;
        prev_e = o_e;
        if (o_e) e_cnt++;
        if (o_valid) begin
            valid_cnt++;
            if (valid_at == 0) valid_at = real_cyc;
        end
    end

    // Bus and enable driver: planned byte while E is high, noise elsewhere
    always @(negedge i_clk) begin
        if (ena_gate_at != 0 && k == ena_gate_at) begin
            ena_low_left = 10;
            ena_gate_at  = 0;
        end
        if (ena_low_left > 0) begin
            i_ena = 1'b0;
            ena_low_left--;
        end else if (ena_mode != 0) begin
            i_ena = ($urandom_range(0, 3) != 0);
        end else begin
            i_ena = 1'b1;
        end
        if (in_e_high(k)) i_d = pulse_val((k - TAS - 1) / PER);
        else              i_d = 8'($urandom_range(0, 255));
    end

    task automatic wait_idle();
        int tries = 0;
        while (k != 0 && tries < 5000) begin
            @(negedge i_clk);
            tries++;
        end
        if (k != 0) check("idle_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic rs, input int extra_start_at);
        int tries = 0;
        @(negedge i_clk);
        i_rs    = rs;
        i_start = 1'b1;
        do begin
            @(negedge i_clk);
            tries++;
        end while (k == 0 && tries < 200);
        i_start = 1'b0;
        if (k == 0) begin
            check("accept_wait_expired", 32'd0, 32'd1);
            return;
        end
        if (extra_start_at > 0) begin
            tries = 0;
            while (k < extra_start_at && k != 0 && tries < 1000) begin
                @(negedge i_clk);
                tries++;
            end
            i_rs    = ~rs;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        for (int i = 0; i < TB_MAX; i++) plan[i] = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_e", o_e, 1'b0);
        check("rst_rw", o_rw, 1'b0);
        check("rst_data", o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        // Single data read
        plan[0] = DATA_LIT;
        run_op(1'b1, 0);
        check("rd_data", o_data, DATA_LIT);
        check("rd_valid_at", valid_at, LAT1);
        check("rd_timeout", o_timeout, 1'b0);
        check("rd_pulses", e_pulses, R);
        check("rd_e_width", e_cnt, 25 * R);

        // Busy poll: three busy samples, then ready
        plan[0] = 8'h85; plan[1] = 8'h85; plan[2] = 8'h85; plan[3] = 8'h05;
        run_op(1'b0, 0);
        check("poll_valid_at", valid_at, LAT4);
        check("poll_bf", o_bf, 1'b0);
        check("poll_ac", o_ac, 7'h05);
        check("poll_timeout", o_timeout, 1'b0);
        check("poll_pulses", e_pulses, 4 * R);
        check("poll_valid_cnt", valid_cnt, 1);

        // Poll timeout: BF never clears
        for (int i = 0; i < TB_MAX; i++) plan[i] = 8'hFF;
        run_op(1'b0, 0);
        check("to_timeout", o_timeout, 1'b1);
        check("to_bf", o_bf, 1'b1);
        check("to_pulses", e_pulses, 4 * R);
        check("to_valid_at", valid_at, LAT4);

        // Asynchronous reset while E is high
        plan[0] = 8'h3C;
        @(negedge i_clk);
        i_rs    = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        tries = 0;
        while (k != 15 && tries < 100) begin
            @(negedge i_clk);
            tries++;
        end
        check("pre_rst_e", o_e, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        check("mid_rst_e", o_e, 1'b0);
        check("mid_rst_rw", o_rw, 1'b0);
        check("mid_rst_release", o_bus_release, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        plan[0] = 8'hC3;
        run_op(1'b1, 0);
        check("post_rst_valid_at", valid_at, LAT1);
        check("post_rst_data", o_data, 8'hC3);

        // Second start during SETUP ignored; enable low for 10 clocks in E high
        plan[0]     = 8'h96;
        ena_gate_at = 10;
        run_op(1'b1, 2);
        check("gate_valid_cnt", valid_cnt, 1);
        check("gate_e_width", e_cnt, GATE_E);
        check("gate_valid_at", valid_at, GATE_LAT);
        check("gate_data", o_data, 8'h96);

        // Randomized operations with random enable gating
        for (int n = 0; n < 40; n++) begin
            logic rs;
            int   nb;
            rs       = 1'($urandom_range(0, 1));
            ena_mode = (n % 2);
            if (rs) begin
                plan[0] = 8'($urandom_range(0, 255));
            end else begin
                nb = $urandom_range(0, TB_MAX);
                for (int i = 0; i < TB_MAX; i++) begin
                    plan[i] = {(i < nb), 7'($urandom_range(0, 127))};
                end
            end
            run_op(rs, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 50) : 0);
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end
        ena_mode = 0;
        repeat (3) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
